// File: rtl/counter_param.sv
// Parametrised up/down counter with load, wrap/saturate boundary handling,
// terminal-count pulse, sticky overflow flag and compare match.
module counter_param #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_VALUE   = 255,
  parameter int unsigned RESET_VALUE = 0,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
  input  logic [WIDTH-1:0] cmp_value,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic             be;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;
  logic             ovf_next;

  // Load masks the boundary event, so a load at MAX never raises tc or ovf.
  assign be = en && !load && (up_dn ? (out == MAX) : (out == '0));

  always_comb begin
    out_next = out;
    tc_next  = 1'b0;
    if (load) begin
      out_next = (load_value > MAX) ? MAX : load_value;
    end else if (en) begin
      if (be) begin
        tc_next = 1'b1;
        if (!SATURATE) begin
          out_next = up_dn ? '0 : MAX;
        end
      end else begin
        out_next = up_dn ? out + WIDTH'(1) : out - WIDTH'(1);
      end
    end
  end

  // A boundary event on the same edge as clr_ovf leaves the flag set.
  always_comb begin
    ovf_next = ovf;
    if (be) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= RST_V;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= out_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

  // out never exceeds MAX, so a cmp_value above MAX can never match.
  assign match = (out == cmp_value);

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param: default 8-bit wrap counter, a modulo-10
// wrap counter driven from a vector table, and a modulo-10 saturating counter.
module tb_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: defaults (WIDTH=8, MAX=255, wrap)
  logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b1, a_ld = 1'b0, a_clr = 1'b0;
  logic [7:0] a_lv = '0, a_cmp = 8'd5;
  logic [7:0] a_out;
  logic       a_tc, a_ovf, a_match;

  // Instance b: WIDTH=8, MAX=9, wrap
  logic       b_rst = 1'b1, b_en = 1'b0, b_up = 1'b0, b_ld = 1'b0, b_clr = 1'b0;
  logic [7:0] b_lv = '0, b_cmp = '0;
  logic [7:0] b_out;
  logic       b_tc, b_ovf, b_match;

  // Instance c: WIDTH=4, MAX=9, saturate
  logic       c_rst = 1'b1, c_en = 1'b0, c_up = 1'b0, c_ld = 1'b0, c_clr = 1'b0;
  logic [3:0] c_lv = '0, c_cmp = 4'd9;
  logic [3:0] c_out;
  logic       c_tc, c_ovf, c_match;

  counter_param dut_a (
    .clk(clk), .reset(a_rst), .en(a_en), .up_dn(a_up), .load(a_ld),
    .load_value(a_lv), .clr_ovf(a_clr), .cmp_value(a_cmp),
    .out(a_out), .tc(a_tc), .ovf(a_ovf), .match(a_match)
  );

  counter_param #(.WIDTH(8), .MAX_VALUE(9), .RESET_VALUE(0), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(b_rst), .en(b_en), .up_dn(b_up), .load(b_ld),
    .load_value(b_lv), .clr_ovf(b_clr), .cmp_value(b_cmp),
    .out(b_out), .tc(b_tc), .ovf(b_ovf), .match(b_match)
  );

  counter_param #(.WIDTH(4), .MAX_VALUE(9), .RESET_VALUE(0), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset(c_rst), .en(c_en), .up_dn(c_up), .load(c_ld),
    .load_value(c_lv), .clr_ovf(c_clr), .cmp_value(c_cmp),
    .out(c_out), .tc(c_tc), .ovf(c_ovf), .match(c_match)
  );

  typedef struct {
    logic       rst, en, up, ld;
    logic [7:0] lv;
    logic       clr;
    logic [7:0] cmp;
    logic [7:0] eo;
    logic       etc, eovf, em;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic c_step(input logic en, input logic up, input logic ld, input logic [3:0] lv,
                        input logic [3:0] eo, input logic etc, input logic eovf, input string nm);
    @(negedge clk);
    c_en = en; c_up = up; c_ld = ld; c_lv = lv;
    @(posedge clk);
    #1;
    chk({nm, ".out"}, 32'(c_out), 32'(eo));
    chk({nm, ".tc"},  32'(c_tc),  32'(etc));
    chk({nm, ".ovf"}, 32'(c_ovf), 32'(eovf));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst  en   up   ld   lv     clr  cmp    eo     tc   ovf  match
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,8'd0,  1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd9,  8'd9, 1'b1,1'b1,1'b1};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd8, 1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd7, 1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd6, 1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd5, 1'b0,1'b1,1'b1};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd4, 1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd3, 1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd2, 1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd1, 1'b0,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd0, 1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd5,  8'd9, 1'b1,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  1'b1,8'd9,  8'd9, 1'b0,1'b0,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,8'd0,  1'b0,8'd12, 8'd0, 1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b1,8'd12, 8'd9, 1'b1,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,8'd200,1'b0,8'd12, 8'd9, 1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  1'b0,8'd12, 8'd0, 1'b1,1'b1,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b1,8'd3,  1'b0,8'd3,  8'd3, 1'b0,1'b1,1'b1};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  1'b1,8'd3,  8'd3, 1'b0,1'b0,1'b1};
    tbl[19] = '{1'b0,1'b0,1'b0,1'b1,8'd9,  1'b0,8'd9,  8'd9, 1'b0,1'b0,1'b1};
    tbl[20] = '{1'b0,1'b1,1'b1,1'b1,8'd4,  1'b0,8'd4,  8'd4, 1'b0,1'b0,1'b1};
    tbl[21] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  1'b0,8'd12, 8'd5, 1'b0,1'b0,1'b0};
    tbl[22] = '{1'b0,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd4,  8'd4, 1'b0,1'b0,1'b1};
    tbl[23] = '{1'b1,1'b1,1'b0,1'b0,8'd0,  1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1};
    tbl[24] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  1'b0,8'd0,  8'd0, 1'b0,1'b0,1'b1};

    // ---- Instance a: free-running 8-bit count, reset released at 17 ns
    a_en = 1'b1;
    #17;
    a_rst = 1'b0;
    chk("a_reset.out", 32'(a_out), 32'd0);
    chk("a_reset.tc",  32'(a_tc),  32'd0);
    chk("a_reset.ovf", 32'(a_ovf), 32'd0);
    for (int i = 1; i <= 257; i++) begin
      logic [7:0] eo;
      eo = 8'(i % 256);
      @(posedge clk);
      #1;
      chk("a_count.out",   32'(a_out),   32'(eo));
      chk("a_count.tc",    32'(a_tc),    32'(i == 256));
      chk("a_count.ovf",   32'(a_ovf),   32'(i >= 256));
      chk("a_count.match", 32'(a_match), 32'(eo == 8'd5));
    end

    // ---- Instance a: asynchronous reset between edges at out=0x37
    for (int n = 0; n < 100 && a_out != 8'h37; n++) begin
      @(posedge clk);
      #1;
    end
    chk("a_reach37.out", 32'(a_out), 32'h37);
    #3;
    a_rst = 1'b1;
    #1;
    chk("a_async.out", 32'(a_out), 32'd0);
    chk("a_async.tc",  32'(a_tc),  32'd0);
    chk("a_async.ovf", 32'(a_ovf), 32'd0);
    #9;
    chk("a_async_hold.out", 32'(a_out), 32'd0);
    #1;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("a_resume1.out", 32'(a_out), 32'd1);
    @(posedge clk);
    #1;
    chk("a_resume2.out", 32'(a_out), 32'd2);
    chk("a_resume2.ovf", 32'(a_ovf), 32'd0);

    // ---- Instance b: MAX=9 wrap, vector table
    for (int unsigned k = 0; k < 25; k++) begin
      @(negedge clk);
      b_rst = tbl[k].rst; b_en = tbl[k].en; b_up = tbl[k].up; b_ld = tbl[k].ld;
      b_lv = tbl[k].lv;   b_clr = tbl[k].clr; b_cmp = tbl[k].cmp;
      @(posedge clk);
      #1;
      chk($sformatf("b_vec%0d.out", k),   32'(b_out),   32'(tbl[k].eo));
      chk($sformatf("b_vec%0d.tc", k),    32'(b_tc),    32'(tbl[k].etc));
      chk($sformatf("b_vec%0d.ovf", k),   32'(b_ovf),   32'(tbl[k].eovf));
      chk($sformatf("b_vec%0d.match", k), 32'(b_match), 32'(tbl[k].em));
    end

    // ---- Instance c: MAX=9 saturate
    @(negedge clk);
    c_rst = 1'b0;
    c_step(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, "c_load7");
    c_step(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, "c_up8");
    c_step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, "c_up9");
    chk("c_up9.match", 32'(c_match), 32'd1);
    c_step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, "c_sat1");
    c_step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, "c_sat2");
    c_step(1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, "c_endis");
    c_step(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1, "c_load1");
    c_step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "c_dn0");
    c_step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "c_satlo");
    c_step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1, "c_leave");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
Parametrised up/down counter: successor to the fixed 8-bit free-running counter. Adds configurable width and modulo, count enable, direction, synchronous load, and wrap or saturate mode. Also provides a terminal-count pulse, a sticky overflow flag and a compare-match output. Used as a general timebase/event counter inside the design; the 8-bit free-running behaviour is the default configuration.

Parameters:
WIDTH, 8, counter width in bits (1..32)
MAX_VALUE, 255, highest count value; count range is 0..MAX_VALUE; must be <= 2**WIDTH-1
RESET_VALUE, 0, value of out after reset; must be <= MAX_VALUE
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
en  input  1  count enable
up_dn  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_value  input  WIDTH  value loaded when load=1
clr_ovf  input  1  synchronous clear of the ovf flag
cmp_value  input  WIDTH  compare value for match
out  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
ovf  output  1  sticky boundary/overflow flag (registered)
match  output  1  out == cmp_value (combinational from out and cmp_value)

Behaviour:
- reset=1 (asynchronous, any time): out=RESET_VALUE, tc=0, ovf=0 immediately, with no clock edge required. Deassertion takes effect at the next rising edge.
- Priority per edge: reset > load > en > hold.
- load=1: out <= min(load_value, MAX_VALUE). tc <= 0. Load ignores en and direction and never sets ovf.
- en=0, load=0: out holds, tc <= 0.
- Boundary event (BE) = en & !load & ((up_dn & out==MAX_VALUE) | (!up_dn & out==0)).
- en=1, no BE: out <= out+1 (up) or out-1 (down). tc <= 0.
- BE, SATURATE=0: up wraps to 0; down wraps to MAX_VALUE. tc <= 1.
- BE, SATURATE=1: out holds. tc <= 1 on every edge where BE is true, so tc stays high while en stays high at the boundary.
- tc latency: high in the cycle immediately after the edge on which BE was sampled. In wrap mode this is the same cycle in which out shows the wrapped value.
- ovf: set on any BE edge; cleared by clr_ovf=1; if BE and clr_ovf coincide, set wins (ovf=1).
- match: pure compare, no latency. Compare values greater than MAX_VALUE never match.
- Direction change takes effect on the next enabled edge; no pipeline state is involved.
- All arithmetic is WIDTH bits; the modulo is handled by explicit compare against MAX_VALUE, never by natural overflow (except when MAX_VALUE=2**WIDTH-1, where both agree).
- out never leaves 0..MAX_VALUE in any sequence of inputs.

Test Plan:
- Defaults (WIDTH=8, MAX=255, wrap), en=1, up: release reset after 17 ns on a 10 ns clock. Required: out counts 0,1,…,255,0; tc=1 only in the cycle out=0 after wrap; ovf=1 afterwards.
- MAX_VALUE=9, down count from RESET_VALUE=0: out sequence 9,8,…,0,9. tc pulses when out shows 9. Assert clr_ovf → ovf=0 next cycle. Assert clr_ovf on a BE edge → ovf stays 1.
- MAX_VALUE=9, SATURATE=1, up from 7: out sequence 8,9,9,9. tc=1 for each cycle held at 9 with en=1. Drop en → tc=0 next cycle, out=9.
- Load: load_value=200 with MAX_VALUE=9 → out=9. Load and en together, load_value=3 → out=3 (not 4), tc=0. Load while out=MAX, up, en=1 → no tc, no ovf.
- Asynchronous reset mid-count at out=0x37, asserted between edges → out=RESET_VALUE, tc=0, ovf=0 before the next edge. Hold 11 ns, release → counting resumes from RESET_VALUE.
- match: cmp_value=5, counting up → match=1 exactly while out=5. cmp_value=12 with MAX_VALUE=9 → match never asserts.
